register_crypt_fifo: RTL and testbench
======================================

# register_crypt_fifo

Parametrised result buffer for the RSA datapath, the successor to the single-word result register. It captures finished WIDTH-bit results from the modular-exponentiation core into a DEPTH-entry FIFO. It drains them over a valid/ready handshake as OUT_W-bit beats, MSB beat first, toward the chip output pins. The global `ena` and the active-low synchronous `clear` keep the same semantics as the rest of the datapath.

## Interface
- `WIDTH`, 8: result word width; must be a multiple of OUT_W.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `OUT_W`, 4: output beat width; BEATS = WIDTH/OUT_W, at least 1.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `ena`  input  1  global enable; when 0, no state changes.
- `clear`  input  1  synchronous flush, active low; qualified by `ena`.
- `load`  input  1  push request for `R_i`.
- `R_i`  input  WIDTH  result word to capture.
- `C_ready`  input  1  downstream accepts the current beat.
- `C_valid`  output  1  a beat is presented on `C_ex`.
- `C_ex`  output  OUT_W  current beat of the head word.
- `C_last`  output  1  current beat is the final beat of its word.
- `full`  output  1  count == DEPTH.
- `overflow`  output  1  sticky flag: a push was dropped.
- `count`  output  $clog2(DEPTH+1)  number of words stored.

## Operation
- **State:**
  - Word storage `mem[DEPTH]`.
  - Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`.
  - Beat index `beat`, from 0 to BEATS-1.
  - `overflow`.
- **Reset (`rst`=1, asynchronous):** `wp`, `rp`, `count`, `beat` and `overflow` all go to 0. All outputs go to 0. Memory contents are don't-care.
- **`ena`=0:** every register holds. `load`, `clear` and `C_ready` are ignored. Outputs stay stable.
- **`ena`=1 and `clear`=0:**
  - Flush: `wp`, `rp`, `count`, `beat` and `overflow` go to 0.
  - `clear` has priority over `load` and over any pop.
  - A beat presented in that cycle is not transferred, even if `C_ready`=1.
- **`ena`=1 and `clear`=1:**
  - **Beat transfer:** occurs when `C_valid` and `C_ready` are both 1.
    - If `beat` < BEATS-1, `beat` increments.
    - Otherwise `beat` returns to 0, `rp` increments and the word is popped.
  - **Push:** occurs when `load`=1 and either `full`=0 or a word pop happens in the same cycle.
    - `mem[wp]` is written with `R_i` and `wp` increments.
  - **Push dropped:** `load`=1 while `full`=1 and no pop that cycle. Memory is unchanged and `overflow` is set to 1. It clears only on `rst` or `clear`.
  - **Count update:** `count` = `count` + push − pop. A simultaneous push and pop leaves `count` unchanged.
- **Output mapping (combinational from registers):**
  - `C_valid` = (`count` != 0).
  - `C_ex` = `mem[rp]` bits [WIDTH-1-`beat`·OUT_W -: OUT_W] when `C_valid`=1; otherwise 0.
  - `C_last` = `C_valid` && (`beat` == BEATS-1).
  - `full` = (`count` == DEPTH).
- **Handshake rules:**
  - Once `C_valid`=1, `C_ex` and `C_last` hold until the beat transfers, unless `clear` or `rst` intervenes.
  - `C_valid` never depends combinationally on `C_ready`.

## Timing
- **Push latency:** a push into an empty FIFO at edge N gives `C_valid`=1 and the MSB beat of that word after edge N.
- **Throughput:** with `C_ready` held high, one beat per enabled cycle, so one word every BEATS cycles. Back-to-back words have no bubble.
- **BEATS=1:** `C_last` equals `C_valid`, and every transfer pops a word.
- **Pointer wrap:** both pointers wrap from DEPTH-1 to 0 with no gap.
- **Full with pop:** a push is accepted on the cycle that the final beat of the head word transfers.
- **Empty with push and `C_ready`=1:** the push is taken. No transfer occurs that cycle because `C_valid` was 0.
- **`rst` mid-word:** the partially drained word is discarded. Outputs are 0 from the reset assertion onward.
- **`clear` mid-word:** same as `rst`, but effective at the next enabled rising edge.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, OUT_W=4.
1. **Reset:** assert `rst` asynchronously mid-cycle → `C_valid`=0, `C_ex`=0, `count`=0, `full`=0 and `overflow`=0 immediately, then held through release.
2. **Single word:** push 0xA5, then `C_ready`=1 → beats 0xA then 0x5 on consecutive cycles, `C_last`=1 on 0x5 only. `count` goes 1 → 0 and `C_valid` drops afterwards.
3. **Fill and overflow:** push 0x11, 0x22, 0x33, 0x44 → `full`=1, `count`=4. Push 0x55 → dropped, `overflow`=1. Drain → beats 1,1,2,2,3,3,4,4 with no gaps.
4. **Wrap and simultaneous events:**
   - Fill with 0x11, 0x22, 0x33, 0x44, drain 0x11, push 0x66 → 0x66 is stored in slot 0.
   - With the FIFO full, push 0x77 on the cycle the final beat of the head word (0x22) transfers → accepted, `count` stays 4, `overflow` stays 0.
   - Drain → beats 3,3,4,4,6,6,7,7.
5. **Backpressure and `ena`:** hold `C_ready`=0 for 5 cycles with 0xC3 at the head → `C_ex`=0xC held. Then set `ena`=0 with `C_ready`=1 and `load`=1 → no transfer, no push, all outputs stable.
6. **`clear` priority:** at `count`=2, mid-word at beat 1, drive `clear`=0, `load`=1 and `C_ready`=1 → next cycle `count`=0, `C_valid`=0, `overflow`=0. The pushed word is not stored.

Source files
------------

// File: rtl/register_crypt_fifo.sv
// Result buffer for the RSA datapath: stores finished WIDTH-bit results in a
// DEPTH-entry FIFO and drains them as OUT_W-bit beats, MSB beat first.
module register_crypt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OUT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       clear,
  input  logic                       load,
  input  logic [WIDTH-1:0]           R_i,
  input  logic                       C_ready,
  output logic                       C_valid,
  output logic [OUT_W-1:0]           C_ex,
  output logic                       C_last,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int BEATS = WIDTH / OUT_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [BW-1:0]    r_beat;
  logic             r_overflow;

  logic             w_valid;
  logic             w_full;
  logic             w_last_beat;
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_head;
  logic [OUT_W-1:0] w_beat_data;

  assign w_valid     = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_xfer      = w_valid && C_ready;
  assign w_pop       = w_xfer && w_last_beat;
  // A full FIFO still accepts a word when the head word leaves in the same cycle.
  assign w_push      = load && (!w_full || w_pop);
  assign w_drop      = load && w_full && !w_pop;
  assign w_head      = r_mem[r_rp];

  // NOTE: every variable in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_beat_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BW'(b)) w_beat_data = w_head[WIDTH-1-b*OUT_W -: OUT_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else if (ena) begin
      if (!clear) begin
        r_wp       <= '0;
        r_rp       <= '0;
        r_count    <= '0;
        r_beat     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_xfer) begin
          if (w_last_beat) begin
            r_beat <= '0;
            r_rp   <= r_rp + PW'(1);
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        if (w_push) r_wp <= r_wp + PW'(1);
        if (w_drop) r_overflow <= 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: storage has no reset; a word is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (ena && clear && w_push) r_mem[r_wp] <= R_i;
  end

  assign C_valid  = w_valid;
  assign C_ex     = w_valid ? w_beat_data : '0;
  assign C_last   = w_valid && w_last_beat;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign count    = r_count;

endmodule

// File: tb/tb_register_crypt_fifo.sv
// Directed bench for register_crypt_fifo (WIDTH=8, DEPTH=4, OUT_W=4) with
// hand-computed expected values checked by immediate assertions.
module tb_register_crypt_fifo;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       clear;
  logic       load;
  logic [7:0] r_i;
  logic       c_ready;
  logic       c_valid;
  logic [3:0] c_ex;
  logic       c_last;
  logic       full;
  logic       overflow;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;

  register_crypt_fifo #(.WIDTH(8), .DEPTH(4), .OUT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .clear    (clear),
    .load     (load),
    .R_i      (r_i),
    .C_ready  (c_ready),
    .C_valid  (c_valid),
    .C_ex     (c_ex),
    .C_last   (c_last),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    load = 1'b1;
    r_i  = d;
    step();
    load = 1'b0;
  endtask

  logic [3:0] exp3 [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
  logic [3:0] exp4 [8] = '{4'h3, 4'h3, 4'h4, 4'h4, 4'h6, 4'h6, 4'h7, 4'h7};

  initial begin
    rst = 1'b1; ena = 1'b1; clear = 1'b1; load = 1'b0; r_i = '0; c_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("por_valid", c_valid, 0);
    check("por_count", count, 0);

    // 1. asynchronous reset mid-cycle with a word present
    push(8'h5A);
    check("pre_rst_valid", c_valid, 1);
    check("pre_rst_ex", c_ex, 4'h5);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", c_valid, 0);
    check("rst_ex", c_ex, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    step();
    check("rst_hold_valid", c_valid, 0);
    rst = 1'b0;
    step();
    check("rst_rel_valid", c_valid, 0);
    check("rst_rel_count", count, 0);

    // 2. single word, MSB beat first
    push(8'hA5);
    check("sw_count1", count, 1);
    check("sw_ex_hi", c_ex, 4'hA);
    check("sw_last_hi", c_last, 0);
    c_ready = 1'b1;
    step();
    check("sw_ex_lo", c_ex, 4'h5);
    check("sw_last_lo", c_last, 1);
    check("sw_count_mid", count, 1);
    step();
    check("sw_count0", count, 0);
    check("sw_valid_off", c_valid, 0);
    check("sw_ex_off", c_ex, 0);
    c_ready = 1'b0;

    // 3. fill, overflow, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("fill_count", count, 4);
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 0);
    push(8'h55);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 4);
    c_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain3_valid", c_valid, 1);
      check("drain3_ex", c_ex, exp3[i]);
      check("drain3_last", c_last, i % 2);
      step();
    end
    c_ready = 1'b0;
    check("drain3_empty", count, 0);
    check("drain3_ovf_sticky", overflow, 1);
    clear = 1'b0;
    step();
    clear = 1'b1;
    check("clr_ovf", overflow, 0);

    // 4. wrap and push during the final beat of a full FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    c_ready = 1'b1;
    step(); step();
    c_ready = 1'b0;
    check("wrap_count3", count, 3);
    check("wrap_head", c_ex, 4'h2);
    push(8'h66);
    check("wrap_full", full, 1);
    c_ready = 1'b1;
    step();
    check("fp_last", c_last, 1);
    check("fp_ex", c_ex, 4'h2);
    push(8'h77);
    check("fp_count", count, 4);
    check("fp_ovf", overflow, 0);
    check("fp_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      check("drain4_ex", c_ex, exp4[i]);
      step();
    end
    check("drain4_empty", c_valid, 0);
    c_ready = 1'b0;

    // 5. backpressure, then ena low
    push(8'hC3);
    for (int i = 0; i < 5; i++) begin
      check("bp_ex", c_ex, 4'hC);
      check("bp_valid", c_valid, 1);
      step();
    end
    ena = 1'b0; c_ready = 1'b1; load = 1'b1; r_i = 8'h99;
    step(); step();
    check("ena_ex", c_ex, 4'hC);
    check("ena_last", c_last, 0);
    check("ena_count", count, 1);
    ena = 1'b1; load = 1'b0;
    step();
    check("ena_resume_ex", c_ex, 4'h3);
    check("ena_resume_last", c_last, 1);
    step();
    check("ena_resume_empty", count, 0);
    c_ready = 1'b0;

    // 6. clear beats load and pop
    push(8'h81); push(8'h82);
    c_ready = 1'b1;
    step();
    check("clrp_mid_ex", c_ex, 4'h1);
    check("clrp_mid_count", count, 2);
    clear = 1'b0; load = 1'b1; r_i = 8'hEE;
    step();
    check("clrp_count", count, 0);
    check("clrp_valid", c_valid, 0);
    check("clrp_ovf", overflow, 0);
    check("clrp_ex", c_ex, 0);
    clear = 1'b1; load = 1'b0; c_ready = 1'b0;
    step();
    check("clrp_after_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
